// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---- pipe_pkg : shared encodings for the pipeline hazard controller | rev 1.0 ----
`default_nettype none

package pipe_pkg;

   localparam logic [1:0] PC_SEL_NPC    = 2'b00;
   localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
   localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } hz_state_t;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
// ---- pipe_hazard_ctrl_if : ID/EX status in, IF/ID control out | rev 1.0 ----
`default_nettype none

interface pipe_hazard_ctrl_if
   import pipe_pkg::*;
#(
   parameter int CNT_W = 32
);

   logic [4:0]       in_id_rs;
   logic [4:0]       in_id_rt;
   logic             in_id_use_rs;
   logic             in_id_use_rt;
   logic             in_id_branch_taken;
   logic             in_id_jump;
   logic [4:0]       in_ex_rd;
   logic             in_ex_wena;
   logic             in_ex_is_load;
   logic             in_ex_md_start;

   logic             out_stall;
   logic             out_bubble;
   logic [1:0]       out_pc_sel;
   logic             out_md_busy;
   logic             out_md_done;
   logic [CNT_W-1:0] out_stall_cnt;

   modport master (
      output in_id_rs, in_id_rt, in_id_use_rs, in_id_use_rt,
             in_id_branch_taken, in_id_jump,
             in_ex_rd, in_ex_wena, in_ex_is_load, in_ex_md_start,
      input  out_stall, out_bubble, out_pc_sel, out_md_busy, out_md_done,
             out_stall_cnt
   );

   modport slave (
      input  in_id_rs, in_id_rt, in_id_use_rs, in_id_use_rt,
             in_id_branch_taken, in_id_jump,
             in_ex_rd, in_ex_wena, in_ex_is_load, in_ex_md_start,
      output out_stall, out_bubble, out_pc_sel, out_md_busy, out_md_done,
             out_stall_cnt
   );

endinterface : pipe_hazard_ctrl_if

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// ---- sat_counter : enabled up-counter that sticks at all-ones | rev 1.0 ----
`default_nettype none

module sat_counter
   import pipe_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  wire logic             in_clk,
   input  wire logic             in_rst,
   input  wire logic             in_en,
   output logic      [WIDTH-1:0] out_cnt
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (in_en && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign out_cnt = cnt_q;

endmodule : sat_counter

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ---- pipe_hazard_ctrl : load-use detect, mult/div sequencing, PC select | rev 1.0 ----
`default_nettype none

module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MD_LATENCY = 32,
   parameter int CNT_W      = 32
) (
   input  wire logic         in_clk,
   input  wire logic         in_rst,
   pipe_hazard_ctrl_if.slave bus
);

   localparam logic [7:0] MD_LAT_C = 8'(MD_LATENCY);

   hz_state_t  state_q;
   hz_state_t  state_d;
   logic [7:0] md_cnt_q;
   logic [7:0] md_cnt_d;
   logic       md_done_q;
   logic       md_done_d;

   logic       load_use;
   logic       md_accept;
   logic       stall;
   logic [1:0] pc_sel;

   always_comb begin
      load_use = bus.in_ex_is_load & bus.in_ex_wena & (bus.in_ex_rd != REG_ZERO) &
                 ((bus.in_id_use_rs & (bus.in_id_rs == bus.in_ex_rd)) |
                  (bus.in_id_use_rt & (bus.in_id_rt == bus.in_ex_rd)));
   end

   always_comb begin
      state_d   = state_q;
      md_cnt_d  = md_cnt_q;
      md_done_d = 1'b0;
      md_accept = 1'b0;
      stall     = 1'b0;
      case (state_q)
         RUN: begin
            // A start in the same cycle as a load-use hazard covers that stall too.
            stall = load_use;
            if (bus.in_ex_md_start) begin
               md_accept = 1'b1;
               stall     = 1'b1;
               state_d   = MD_BUSY;
               md_cnt_d  = MD_LAT_C;
            end
         end
         MD_BUSY: begin
            stall    = 1'b1;
            md_cnt_d = md_cnt_q - 8'd1;
            if (md_cnt_q <= 8'd1) begin
               md_cnt_d  = 8'd0;
               state_d   = RUN;
               md_done_d = 1'b1;
            end
         end
         default: begin
            state_d  = RUN;
            md_cnt_d = 8'd0;
         end
      endcase
   end

   // Redirects wait while stalled: the branch/jump in ID is re-presented once released.
   always_comb begin
      pc_sel = PC_SEL_NPC;
      if (!stall) begin
         if (bus.in_id_jump) begin
            pc_sel = PC_SEL_JUMP;
         end else if (bus.in_id_branch_taken) begin
            pc_sel = PC_SEL_BRANCH;
         end
      end
   end

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         state_q   <= RUN;
         md_cnt_q  <= 8'd0;
         md_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         md_cnt_q  <= md_cnt_d;
         md_done_q <= md_done_d;
      end
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_stall_cnt (
      .in_clk  (in_clk),
      .in_rst  (in_rst),
      .in_en   (stall),
      .out_cnt (bus.out_stall_cnt)
   );

   assign bus.out_stall   = stall;
   assign bus.out_bubble  = stall;
   assign bus.out_pc_sel  = pc_sel;
   assign bus.out_md_busy = (state_q == MD_BUSY);
   assign bus.out_md_done = md_done_q;

endmodule : pipe_hazard_ctrl

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ---- tb_pipe_hazard_ctrl : directed vector table plus multi-cycle sequences | rev 1.0 ----
`default_nettype none

module tb_pipe_hazard_ctrl;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_err;

   pipe_hazard_ctrl_if #(.CNT_W(3)) bus ();

   pipe_hazard_ctrl #(
      .MD_LATENCY (4),
      .CNT_W      (3)
   ) dut (
      .in_clk (clk),
      .in_rst (rst_n),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       use_rs;
      logic       use_rt;
      logic [4:0] rd;
      logic       wena;
      logic       load;
      logic       br;
      logic       jmp;
      logic       exp_stall;
      logic [1:0] exp_pc;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.in_id_rs           = 5'd0;
      bus.in_id_rt           = 5'd0;
      bus.in_id_use_rs       = 1'b0;
      bus.in_id_use_rt       = 1'b0;
      bus.in_id_branch_taken = 1'b0;
      bus.in_id_jump         = 1'b0;
      bus.in_ex_rd           = 5'd0;
      bus.in_ex_wena         = 1'b0;
      bus.in_ex_is_load      = 1'b0;
      bus.in_ex_md_start     = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drive_load_use(input logic [4:0] r);
      bus.in_ex_is_load = 1'b1;
      bus.in_ex_wena    = 1'b1;
      bus.in_ex_rd      = r;
      bus.in_id_rs      = r;
      bus.in_id_use_rs  = 1'b1;
   endtask

   initial begin
      int busy_seen;
      int done_seen;
      n_checks = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      clear_inputs();

      vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
      vecs[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
      vecs[2]  = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
      vecs[3]  = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
      vecs[4]  = '{5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
      vecs[5]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
      vecs[6]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
      vecs[7]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00};
      vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01};
      vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10};
      vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10};
      vecs[11] = '{5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00};
      vecs[12] = '{5'd6, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01};

      // Reset state
      @(negedge clk);
      #2;
      chk("rst_stall", 32'(bus.out_stall), 32'd0);
      chk("rst_bubble", 32'(bus.out_bubble), 32'd0);
      chk("rst_pc_sel", 32'(bus.out_pc_sel), 32'd0);
      chk("rst_busy", 32'(bus.out_md_busy), 32'd0);
      chk("rst_done", 32'(bus.out_md_done), 32'd0);
      chk("rst_cnt", 32'(bus.out_stall_cnt), 32'd0);
      rst_n = 1'b1;

      // Combinational vector table, all in RUN
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         bus.in_id_rs           = vecs[i].rs;
         bus.in_id_rt           = vecs[i].rt;
         bus.in_id_use_rs       = vecs[i].use_rs;
         bus.in_id_use_rt       = vecs[i].use_rt;
         bus.in_ex_rd           = vecs[i].rd;
         bus.in_ex_wena         = vecs[i].wena;
         bus.in_ex_is_load      = vecs[i].load;
         bus.in_id_branch_taken = vecs[i].br;
         bus.in_id_jump         = vecs[i].jmp;
         #2;
         chk($sformatf("vec%0d_stall", i), 32'(bus.out_stall), 32'(vecs[i].exp_stall));
         chk($sformatf("vec%0d_bubble", i), 32'(bus.out_bubble), 32'(vecs[i].exp_stall));
         chk($sformatf("vec%0d_pc_sel", i), 32'(bus.out_pc_sel), 32'(vecs[i].exp_pc));
         chk($sformatf("vec%0d_busy", i), 32'(bus.out_md_busy), 32'd0);
      end
      @(negedge clk);
      clear_inputs();
      #2;
      chk("table_stall_cnt", 32'(bus.out_stall_cnt), 32'd4);

      // Single load-use stall clears once the load leaves EX
      do_reset();
      drive_load_use(5'd5);
      #2;
      chk("lu_stall", 32'(bus.out_stall), 32'd1);
      chk("lu_cnt_before", 32'(bus.out_stall_cnt), 32'd0);
      @(negedge clk);
      clear_inputs();
      #2;
      chk("lu_stall_after", 32'(bus.out_stall), 32'd0);
      chk("lu_cnt_after", 32'(bus.out_stall_cnt), 32'd1);

      // MD run with branch held, ignored start while busy, back-to-back start
      do_reset();
      bus.in_id_branch_taken = 1'b1;
      bus.in_ex_md_start     = 1'b1;
      #2;
      chk("md_start_stall", 32'(bus.out_stall), 32'd1);
      chk("md_start_bubble", 32'(bus.out_bubble), 32'd1);
      chk("md_start_busy", 32'(bus.out_md_busy), 32'd0);
      chk("md_start_pc", 32'(bus.out_pc_sel), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.in_ex_md_start = (i == 1);
         #2;
         chk($sformatf("md_busy%0d_stall", i), 32'(bus.out_stall), 32'd1);
         chk($sformatf("md_busy%0d_busy", i), 32'(bus.out_md_busy), 32'd1);
         chk($sformatf("md_busy%0d_done", i), 32'(bus.out_md_done), 32'd0);
         chk($sformatf("md_busy%0d_pc", i), 32'(bus.out_pc_sel), 32'd0);
      end
      @(negedge clk);
      bus.in_ex_md_start = 1'b0;
      #2;
      chk("md_done", 32'(bus.out_md_done), 32'd1);
      chk("md_done_stall", 32'(bus.out_stall), 32'd0);
      chk("md_done_busy", 32'(bus.out_md_busy), 32'd0);
      chk("md_done_pc", 32'(bus.out_pc_sel), 32'd1);
      chk("md_done_cnt", 32'(bus.out_stall_cnt), 32'd5);
      bus.in_ex_md_start = 1'b1;
      #1;
      chk("b2b_stall", 32'(bus.out_stall), 32'd1);
      chk("b2b_pc", 32'(bus.out_pc_sel), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.in_ex_md_start = 1'b0;
         #2;
         chk($sformatf("b2b_busy%0d", i), 32'(bus.out_md_busy), 32'd1);
         chk($sformatf("b2b_done%0d", i), 32'(bus.out_md_done), 32'd0);
      end
      @(negedge clk);
      #2;
      chk("b2b_done", 32'(bus.out_md_done), 32'd1);
      chk("b2b_cnt_sat", 32'(bus.out_stall_cnt), 32'd7);
      @(negedge clk);
      #2;
      chk("b2b_done_gone", 32'(bus.out_md_done), 32'd0);

      // Load-use together with MD start: one stall, start accepted
      do_reset();
      drive_load_use(5'd9);
      bus.in_ex_md_start = 1'b1;
      #2;
      chk("lu_md_stall", 32'(bus.out_stall), 32'd1);
      @(negedge clk);
      clear_inputs();
      #2;
      chk("lu_md_busy", 32'(bus.out_md_busy), 32'd1);
      chk("lu_md_cnt", 32'(bus.out_stall_cnt), 32'd1);

      // Asynchronous reset mid-busy
      do_reset();
      bus.in_ex_md_start = 1'b1;
      @(negedge clk);
      bus.in_ex_md_start = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_stall", 32'(bus.out_stall), 32'd0);
      chk("arst_busy", 32'(bus.out_md_busy), 32'd0);
      chk("arst_done", 32'(bus.out_md_done), 32'd0);
      chk("arst_cnt", 32'(bus.out_stall_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #2;
         if (bus.out_md_done) done_seen++;
      end
      chk("arst_no_done", 32'(done_seen), 32'd0);
      bus.in_ex_md_start = 1'b1;
      @(negedge clk);
      bus.in_ex_md_start = 1'b0;
      busy_seen = 0;
      done_seen = 0;
      for (int i = 0; i < 20 && done_seen == 0; i++) begin
         #2;
         if (bus.out_md_busy) busy_seen++;
         if (bus.out_md_done) done_seen = 1;
         @(negedge clk);
      end
      chk("fresh_busy_len", 32'(busy_seen), 32'd4);
      chk("fresh_done_seen", 32'(done_seen), 32'd1);

      // Counter saturation with a 3-bit counter
      do_reset();
      drive_load_use(5'd12);
      for (int i = 0; i < 10; i++) @(negedge clk);
      clear_inputs();
      #2;
      chk("sat_cnt", 32'(bus.out_stall_cnt), 32'd7);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_pipe_hazard_ctrl

`default_nettype wire
